// File: rtl/bsg_sipo_drain_scheduler.sv
// Drain controller for a multi-deque SIPO FIFO: packs available words into one
// registered beat. Optional stats counters: define BSG_SIPO_DRAIN_SCHEDULER_STATS_EN.
module bsg_sipo_drain_scheduler #(
    parameter int width_p   = 8,
    parameter int els_p     = 4,
    parameter int timeout_p = 16
) (
    input  logic                         clk_i,
    input  logic                         reset_i,
    input  logic [els_p-1:0]             sipo_valid_i,
    input  logic [els_p*width_p-1:0]     sipo_data_i,
    output logic [$clog2(els_p+1)-1:0]   sipo_yumi_cnt_o,
    input  logic                         flush_i,
    output logic                         beat_valid_o,
    output logic [els_p*width_p-1:0]     beat_data_o,
    output logic [$clog2(els_p+1)-1:0]   beat_count_o,
    input  logic                         beat_ready_i,
    output logic                         idle_o
`ifdef BSG_SIPO_DRAIN_SCHEDULER_STATS_EN
   ,output logic [15:0]                  stat_full_beats_o
   ,output logic [15:0]                  stat_partial_beats_o
`endif
);

    localparam int cw_lp = $clog2(els_p+1);
    localparam int tw_lp = (timeout_p == 0) ? 1 : $clog2(timeout_p+1);

    logic                     beat_valid_q, beat_valid_d;
    logic [els_p*width_p-1:0] beat_data_q, beat_data_d;
    logic [cw_lp-1:0]         beat_count_q, beat_count_d;
    logic [tw_lp-1:0]         timer_q, timer_d;

    logic [cw_lp-1:0]         avail;
    logic [els_p*width_p-1:0] masked_data;
    logic                     full, expired, slot_free, load;

    always_comb begin
        avail = '0;
        for (int i = 0; i < els_p; i++)
            avail = avail + cw_lp'(sipo_valid_i[i]);
    end

    // Words beyond the dequeued count are zeroed so the beat never leaks stale FIFO slots.
    always_comb begin
        masked_data = '0;
        for (int i = 0; i < els_p; i++)
            if (cw_lp'(i) < avail)
                masked_data[i*width_p +: width_p] = sipo_data_i[i*width_p +: width_p];
    end

    assign full      = (avail == cw_lp'(els_p));
    assign expired   = (timeout_p != 0) && (timer_q == tw_lp'(timeout_p));
    assign slot_free = ~beat_valid_q | beat_ready_i;
    assign load      = slot_free & (full | ((avail != '0) & (flush_i | expired)));

    always_comb begin
        beat_valid_d = beat_valid_q;
        beat_data_d  = beat_data_q;
        beat_count_d = beat_count_q;
        if (load) begin
            beat_valid_d = 1'b1;
            beat_data_d  = masked_data;
            beat_count_d = avail;
        end else if (beat_valid_q & beat_ready_i) begin
            beat_valid_d = 1'b0;
        end
    end

    // Timer saturates at timeout_p so a blocked partial beat stays expired until it drains.
    always_comb begin
        timer_d = timer_q;
        if (load || avail == '0)
            timer_d = '0;
        else if (timeout_p != 0 && !full && timer_q < tw_lp'(timeout_p))
            timer_d = timer_q + 1'b1;
    end

`ifdef BSG_SIPO_DRAIN_SCHEDULER_STATS_EN
    logic [15:0] full_cnt_q, full_cnt_d, part_cnt_q, part_cnt_d;

    always_comb begin
        full_cnt_d = full_cnt_q;
        part_cnt_d = part_cnt_q;
        if (load && full && full_cnt_q != 16'hffff)
            full_cnt_d = full_cnt_q + 16'd1;
        if (load && !full && part_cnt_q != 16'hffff)
            part_cnt_d = part_cnt_q + 16'd1;
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            full_cnt_q <= '0;
            part_cnt_q <= '0;
        end else begin
            full_cnt_q <= full_cnt_d;
            part_cnt_q <= part_cnt_d;
        end
    end

    assign stat_full_beats_o    = full_cnt_q;
    assign stat_partial_beats_o = part_cnt_q;
`endif

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            beat_valid_q <= 1'b0;
            beat_data_q  <= '0;
            beat_count_q <= '0;
            timer_q      <= '0;
        end else begin
            beat_valid_q <= beat_valid_d;
            beat_data_q  <= beat_data_d;
            beat_count_q <= beat_count_d;
            timer_q      <= timer_d;
        end
    end

    assign sipo_yumi_cnt_o = (reset_i || !load) ? '0 : avail;
    assign beat_valid_o    = beat_valid_q;
    assign beat_data_o     = beat_data_q;
    assign beat_count_o    = beat_count_q;
    assign idle_o          = ~beat_valid_q & (avail == '0) & (timer_q == '0);

endmodule

// File: tb/tb_bsg_sipo_drain_scheduler.sv
// Randomized scoreboard bench for bsg_sipo_drain_scheduler (width 8, 4 words, timeout 4).
module tb_bsg_sipo_drain_scheduler;

    localparam int W  = 8;
    localparam int E  = 4;
    localparam int TO = 4;

    logic          clk = 1'b0;
    logic          reset_i;
    logic [E-1:0]  sipo_valid_i;
    logic [E*W-1:0] sipo_data_i;
    logic [2:0]    sipo_yumi_cnt_o;
    logic          flush_i;
    logic          beat_valid_o;
    logic [E*W-1:0] beat_data_o;
    logic [2:0]    beat_count_o;
    logic          beat_ready_i;
    logic          idle_o;
`ifdef BSG_SIPO_DRAIN_SCHEDULER_STATS_EN
    logic [15:0]   stat_full_beats_o, stat_partial_beats_o;
`endif

    bsg_sipo_drain_scheduler #(.width_p(W), .els_p(E), .timeout_p(TO)) dut (
        .clk_i(clk), .reset_i(reset_i),
        .sipo_valid_i(sipo_valid_i), .sipo_data_i(sipo_data_i),
        .sipo_yumi_cnt_o(sipo_yumi_cnt_o), .flush_i(flush_i),
        .beat_valid_o(beat_valid_o), .beat_data_o(beat_data_o),
        .beat_count_o(beat_count_o), .beat_ready_i(beat_ready_i),
        .idle_o(idle_o)
`ifdef BSG_SIPO_DRAIN_SCHEDULER_STATS_EN
       ,.stat_full_beats_o(stat_full_beats_o)
       ,.stat_partial_beats_o(stat_partial_beats_o)
`endif
    );

    always #5 clk = ~clk;

    typedef struct { logic [31:0] data; int cnt; } beat_t;
    beat_t sb_q[$];

    int compared = 0;
    int mismatched = 0;

    // Reference state: is a beat sitting in the output slot, how long a partial has waited.
    bit m_held = 0;
    int m_timer = 0;
    int m_full = 0, m_part = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // One cycle: drive at negedge+1, predict at negedge+2, record the loaded beat after the posedge.
    task automatic step(input int av, input logic [31:0] d, input bit fl, input bit rdy);
        bit slot_free, load, have_new;
        logic [3:0] v;
        logic [31:0] md;
        beat_t nb;
        @(negedge clk);
        #1;
        v = 4'((1 << av) - 1);
        sipo_valid_i = v;
        sipo_data_i  = d;
        flush_i      = fl;
        beat_ready_i = rdy;
        #1;
        slot_free = !m_held || rdy;
        load = slot_free && (av == E || (av != 0 && (fl || (m_timer == TO))));
        check("yumi_cnt", 32'(sipo_yumi_cnt_o), load ? 32'(av) : 32'd0);
        check("idle", 32'(idle_o), 32'(!m_held && av == 0 && m_timer == 0));
        have_new = 0;
        if (load) begin
            md = (av == E) ? d : (d & ((32'h1 << (av*8)) - 32'h1));
            nb.data = md;
            nb.cnt = av;
            have_new = 1;
            m_held = 1;
            if (av == E) m_full++; else m_part++;
        end else if (m_held && rdy) begin
            m_held = 0;
        end
        if (load || av == 0) m_timer = 0;
        else if (av < E && m_timer < TO) m_timer++;
        @(posedge clk);
        #1;
        if (have_new) sb_q.push_back(nb);
    endtask

    // Monitor: slot content must match the oldest outstanding expected beat.
    initial begin
        forever begin
            @(negedge clk);
            #3;
            if (!reset_i) begin
                check("beat_valid", 32'(beat_valid_o), 32'(sb_q.size() != 0));
                if (beat_valid_o && sb_q.size() != 0) begin
                    check("beat_data", beat_data_o, sb_q[0].data);
                    check("beat_count", 32'(beat_count_o), 32'(sb_q[0].cnt));
                    if (beat_ready_i) void'(sb_q.pop_front());
                end
            end
        end
    end

    task automatic do_reset_mid_hold();
        #1;
        sipo_valid_i = 4'b1111;
        beat_ready_i = 1'b1;
        reset_i = 1'b1;
        #1;
        check("rst_beat_valid", 32'(beat_valid_o), 32'd0);
        check("rst_yumi_cnt", 32'(sipo_yumi_cnt_o), 32'd0);
        m_held = 0; m_timer = 0; m_full = 0; m_part = 0;
        sb_q.delete();
        sipo_valid_i = '0;
        flush_i = 1'b0;
        @(negedge clk);
        #1;
        reset_i = 1'b0;
        #1;
        check("post_rst_idle", 32'(idle_o), 32'd1);
    endtask

    initial begin
        int av;
        reset_i = 1'b1;
        sipo_valid_i = '0;
        sipo_data_i = '0;
        flush_i = 1'b0;
        beat_ready_i = 1'b0;
        #3;
        check("reset_valid", 32'(beat_valid_o), 32'd0);
        check("reset_data", beat_data_o, 32'd0);
        check("reset_count", 32'(beat_count_o), 32'd0);
        check("reset_idle", 32'(idle_o), 32'd1);
        check("reset_yumi", 32'(sipo_yumi_cnt_o), 32'd0);
        @(negedge clk);
        #1;
        reset_i = 1'b0;

        // full beat
        step(4, 32'h44332211, 0, 1);
        step(0, 32'h0, 0, 1);
        // timeout of a two-word partial
        for (int i = 0; i < 5; i++) step(2, 32'hdead2211, 0, 1);
        step(0, 32'h0, 0, 1);
        // flush of a single word
        step(1, 32'h123456aa, 1, 1);
        step(0, 32'h0, 0, 1);
        // backpressure then back-to-back
        step(4, 32'h04030201, 0, 0);
        for (int i = 0; i < 6; i++) step(4, 32'h88776655, 0, 0);
        step(4, 32'hccbbaa99, 0, 1);
        step(0, 32'h0, 0, 1);
        // flush asserted while blocked, drains when slot frees
        step(4, 32'h0a0b0c0d, 0, 0);
        step(3, 32'h00112233, 1, 0);
        step(3, 32'h00112233, 1, 1);
        step(0, 32'h0, 1, 1);
        step(0, 32'h0, 0, 1);
`ifdef BSG_SIPO_DRAIN_SCHEDULER_STATS_EN
        @(negedge clk); #2;
        check("stat_full", 32'(stat_full_beats_o), 32'(m_full));
        check("stat_partial", 32'(stat_partial_beats_o), 32'(m_part));
`endif
        // reset while a beat is held
        step(4, 32'h55aa55aa, 0, 0);
        step(4, 32'h55aa55aa, 0, 0);
        do_reset_mid_hold();

        av = 0;
        for (int n = 0; n < 600; n++) begin
            if ($urandom_range(0, 3) == 0) av = $urandom_range(0, 4);
            step(av, $urandom, ($urandom_range(0, 9) == 0), ($urandom_range(0, 9) < 7));
        end
        for (int n = 0; n < 3; n++) step(0, 32'h0, 0, 1);
`ifdef BSG_SIPO_DRAIN_SCHEDULER_STATS_EN
        @(negedge clk); #2;
        check("stat_full_end", 32'(stat_full_beats_o), 32'(m_full));
        check("stat_partial_end", 32'(stat_partial_beats_o), 32'(m_part));
`endif
        @(negedge clk); #4;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/bsg_sipo_drain_scheduler.md
Name: bsg_sipo_drain_scheduler

Overview:
- Downstream controller for a single-enque, multi-deque serial-in/parallel-out FIFO.
- Each cycle it decides how many words to dequeue (drives the FIFO's yumi count) and packs them into one wide beat held in a registered output slot with a valid/ready handshake.
- Full beats leave as soon as els_p words are present; partial beats leave on timeout or on an explicit flush request.

Parameters:
- width_p, (required), width of one FIFO word.
- els_p, (required), words per beat; equals the FIFO's out_els_p.
- timeout_p, 16, cycles a partial beat may wait before forced drain; 0 disables the timeout (partial beats drain only on flush_i).

Ports:
- clk_i  in  1  clock; single clock domain.
- reset_i  in  1  reset, asynchronous, active-high.
- sipo_valid_i  in  els_p  FIFO valid_o vector; thermometer-coded from bit 0.
- sipo_data_i  in  els_p*width_p  FIFO data_o, word 0 in the LSBs.
- sipo_yumi_cnt_o  out  $clog2(els_p+1)  words dequeued from the FIFO this cycle.
- flush_i  in  1  level; drain any partial beat at the next load opportunity.
- beat_valid_o  out  1  output beat valid (registered).
- beat_data_o  out  els_p*width_p  packed beat; unused upper words are zero.
- beat_count_o  out  $clog2(els_p+1)  number of valid words in the beat, 1..els_p.
- beat_ready_i  in  1  downstream accepts the beat when high with beat_valid_o.
- idle_o  out  1  no beat held, avail==0, timer==0.

Behaviour:
- avail = count of ones in sipo_valid_i; sipo_valid_i is treated as thermometer-coded.
- slot_free = ~beat_valid_r | beat_ready_i.
- load = slot_free & ((avail==els_p) | (avail!=0 & (flush_i | expired))).
- expired = (timeout_p!=0) & (timer_r==timeout_p).
- On load, in the same cycle:
  - sipo_yumi_cnt_o = avail.
  - beat_data_r <= sipo_data_i with words at index >= avail forced to 0.
  - beat_count_r <= avail; beat_valid_r <= 1.
- On no load: sipo_yumi_cnt_o = 0. While reset_i is high, sipo_yumi_cnt_o = 0 combinationally.
- Invariants:
  - sipo_yumi_cnt_o <= avail, and is never in 1..els_p-1 unless a flush or timeout condition holds.
  - A beat is never overwritten unless it is accepted in the same cycle (accept + load is a back-to-back beat).
- Beat handshake: if beat_valid_o & beat_ready_i & ~load, then beat_valid_r <= 0. beat_data_o and beat_count_o hold stable while beat_valid_o is high and beat_ready_i is low.
- Latency: a load on cycle t gives beat_valid_o high on cycle t+1. Throughput is one beat per cycle with beat_ready_i held high.
- Timer (width $clog2(timeout_p+1), min 1):
  - Cleared to 0 on load or when avail==0.
  - Otherwise increments while 0<avail<els_p and timer_r<timeout_p.
  - Saturates at timeout_p while the slot is blocked.
  - Held at 0 when timeout_p==0.
- States (derived from beat_valid_r and avail/timer):
  - IDLE: no beat, avail==0.
  - ACCUM: partial pending, timer running.
  - HOLD: beat held, beat_ready_i low.
  - Transitions: IDLE->ACCUM on 0<avail<els_p; IDLE/ACCUM->HOLD on load; HOLD->IDLE on accept with no load; HOLD->HOLD on accept+load.
- Boundaries:
  - avail grows to els_p in ACCUM: immediate full-beat load, timer cleared.
  - flush_i with avail==0: no effect.
  - flush_i while the slot is blocked: drains at the first slot_free cycle if flush_i is still high.
- Reset values: beat_valid_o=0, beat_data_o=0, beat_count_o=0, timer=0, idle_o=1, sipo_yumi_cnt_o=0.
- Reset mid-operation: a held beat is discarded; nothing is dequeued during reset.

Optional Feature:
- Macro: BSG_SIPO_DRAIN_SCHEDULER_STATS_EN.
- When defined, adds 16-bit saturating counters on output ports stat_full_beats_o and stat_partial_beats_o.
  - Increment on full loads and partial loads respectively.
  - Cleared by reset_i.
- When undefined, those ports and counters do not exist; all other behaviour is identical.

Test Plan (width_p=8, els_p=4, timeout_p=4):
- Full beat: sipo_valid_i=4'b1111, data words 0x11/0x22/0x33/0x44, beat_ready_i=1 -> yumi_cnt=4 that cycle; next cycle beat_valid_o=1, beat_data_o=0x44332211, beat_count_o=4.
- Timeout: sipo_valid_i=4'b0011 held from cycle 0 -> yumi_cnt=0 on cycles 0-3, yumi_cnt=2 on cycle 4; cycle 5 beat_count_o=2, upper 16 bits of beat_data_o=0.
- Flush: sipo_valid_i=4'b0001, flush_i=1 on cycle 0 -> yumi_cnt=1 on cycle 0; beat_count_o=1 on cycle 1; timer=0.
- Backpressure: beat held, beat_ready_i=0 for 6 cycles with sipo_valid_i=4'b1111 -> yumi_cnt=0 and beat_data_o stable throughout; the cycle beat_ready_i=1 -> yumi_cnt=4 (back-to-back load), beat_valid_o stays 1 with new data.
- Async reset: assert reset_i mid-HOLD between clock edges -> beat_valid_o=0 and sipo_yumi_cnt_o=0 immediately; after release, idle_o=1.
- Stats (macro on): 2 full beats + 1 timeout beat -> stat_full_beats_o=2, stat_partial_beats_o=1.
